// File: rtl/rxif_cfg_pkg.sv
// Shared types for the RX IF configuration sequencer: FSM states, default
// page-select address and the table entry layout.
package rxif_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  localparam int unsigned CFG_ADDR_W = 5;
  localparam int unsigned CFG_DATA_W = 8;
  localparam logic [CFG_ADDR_W-1:0] PAGE_ADDR_DEFAULT = 5'h1F;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/rxif_cfg_table.sv
// Configuration entry storage: one write port, combinational read at ridx,
// cleared to all-zero by synchronous reset.
module rxif_cfg_table
  import rxif_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = CFG_ADDR_W,
  parameter int unsigned DATA_W = CFG_DATA_W,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (we) begin
      addr_d[widx] = waddr;
      data_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign raddr = addr_q[ridx];
  assign rdata = data_q[ridx];

endmodule

// File: rtl/rxif_cfg_sequencer.sv
// Replays a host-written (addr, data) table to the RX IF serial write master,
// dropping page-select writes that would not change the current page.
//
// state    | meaning
// ST_IDLE  | table writable, waiting for start
// ST_LOAD  | examine table[idx]: skip redundant page select or launch request
// ST_ISSUE | wr_valid held until the serial master accepts
module rxif_cfg_sequencer
  import rxif_cfg_pkg::*;
#(
  parameter int unsigned       ADDR_W    = CFG_ADDR_W,
  parameter int unsigned       DATA_W    = CFG_DATA_W,
  parameter int unsigned       DEPTH     = 64,
  parameter logic [ADDR_W-1:0] PAGE_ADDR = PAGE_ADDR_DEFAULT,
  localparam int unsigned      IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_widx,
  input  logic [ADDR_W-1:0] tbl_waddr,
  input  logic [DATA_W-1:0] tbl_wdata,
  output logic              tbl_err,
  input  logic [IDX_W:0]    len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [IDX_W:0]    skip_cnt
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    len_q, len_d;
  logic [IDX_W:0]    skip_cnt_q, skip_cnt_d;
  logic              page_known_q, page_known_d;
  logic [DATA_W-1:0] cur_page_q, cur_page_d;
  logic              done_q, done_d;
  logic              tbl_err_q, tbl_err_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              last;
  logic              tbl_wr_ok;

  assign tbl_wr_ok = tbl_we && (state_q == ST_IDLE);

  rxif_cfg_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk   (clk),
    .nrst  (nrst),
    .we    (tbl_wr_ok),
    .widx  (tbl_widx),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .ridx  (idx_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // len_q is never zero outside IDLE, so len_q-1 cannot wrap where it matters
  assign last = ({1'b0, idx_q} == (len_q - (IDX_W+1)'(1)));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    skip_cnt_d   = skip_cnt_q;
    page_known_d = page_known_q;
    cur_page_d   = cur_page_q;
    done_d       = 1'b0;
    tbl_err_d    = tbl_we && (state_q != ST_IDLE);
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d        = (len > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : len;
          idx_d        = '0;
          page_known_d = 1'b0;
          skip_cnt_d   = '0;
          if (len == '0) done_d = 1'b1;
          else           state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if ((rd_addr == PAGE_ADDR) && page_known_q && (rd_data == cur_page_q)) begin
          skip_cnt_d = skip_cnt_q + (IDX_W+1)'(1);
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = rd_addr;
          wr_data_d  = rd_data;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_ready) begin
          if (wr_addr_q == PAGE_ADDR) begin
            cur_page_d   = wr_data_q;
            page_known_d = 1'b1;
          end
          wr_valid_d = 1'b0;
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      skip_cnt_q   <= '0;
      page_known_q <= 1'b0;
      cur_page_q   <= '0;
      done_q       <= 1'b0;
      tbl_err_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      skip_cnt_q   <= skip_cnt_d;
      page_known_q <= page_known_d;
      cur_page_q   <= cur_page_d;
      done_q       <= done_d;
      tbl_err_q    <= tbl_err_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign tbl_err  = tbl_err_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign skip_cnt = skip_cnt_q;

endmodule
